hola: RTL and testbench

- RC5-32/12/16 key-expansion engine, self-contained with its three working memories.
- At reset the block:
  - packs the 16 secret-key bytes held in its internal key memory into the 4-word L array;
  - builds the 26-word S table from the magic constants;
  - runs the 78-step RC5 mixing loop.
- The finished S table stays in S_RAM for use by a later encrypt/decrypt core.

---
 rtl/rc5_pkg.sv | 35 +++
 rtl/ram_block.sv | 25 ++
 rtl/hola.sv | 140 ++++++++++++++
 tb/tb_hola.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// Shared constants, FSM state type and rotate helper for the RC5-32/12/16 key expansion.
package rc5_pkg;

    localparam int unsigned W      = 32;
    localparam int unsigned U      = 4;
    localparam int unsigned B      = 16;
    localparam int unsigned R      = 12;
    localparam int unsigned T      = 2 * (R + 1);
    localparam int unsigned C      = B / U;
    localparam int unsigned MIX_N  = 3 * T;

    localparam logic [W-1:0] QW = 32'h9E3779B9;
    localparam logic [W-1:0] PW = 32'hB7E15163;

    localparam int unsigned TAW = $clog2(T);
    localparam int unsigned BAW = $clog2(B);
    localparam int unsigned CAW = $clog2(C);
    localparam int unsigned KW  = $clog2(MIX_N);

    typedef enum logic [2:0] {
        StIdle,
        StLoadL,
        StInitS,
        StMix,
        StDone
    } state_e;

    // Rotate left by the low 5 bits; the doubled word makes an amount of 0 a no-op.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [4:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

endpackage

// File: rtl/ram_block.sv
// Simple RAM: combinational read, synchronous write, array never reset.
module ram_block #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [Width-1:0] i_wdata,
    input  logic [AddrW-1:0] i_raddr,
    output logic [Width-1:0] o_rdata
);

    logic [Width-1:0] ram [Depth];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            ram[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = ram[i_raddr];

endmodule

// File: rtl/hola.sv
// RC5-32/12/16 key-expansion engine: packs key bytes into L, builds S from the magic
// constants, then runs the 78-step mixing loop, leaving the schedule in S_RAM.
module hola
    import rc5_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic done
);

    state_e         r_state, w_state_nxt;
    logic [TAW-1:0] r_i, w_i_nxt;
    logic [CAW-1:0] r_j, w_j_nxt;
    logic [KW-1:0]  r_k, w_k_nxt;
    logic [W-1:0]   r_a, w_a_nxt;
    logic [W-1:0]   r_b, w_b_nxt;

    logic [7:0]     w_key_rdata;
    logic [W-1:0]   w_l_rdata, w_s_rdata;
    logic [CAW-1:0] w_l_raddr, w_l_waddr;
    logic [TAW-1:0] w_s_raddr;
    logic [W-1:0]   w_l_wdata, w_s_wdata;
    logic           w_l_we, w_s_we;
    logic [W-1:0]   w_mix_a, w_mix_b, w_sum_ab;

    ram_block #(.Width(8), .Depth(B)) key_RAM (
        .i_clk   (clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata ('0),
        .i_raddr (r_i[BAW-1:0]),
        .o_rdata (w_key_rdata)
    );

    ram_block #(.Width(W), .Depth(C)) L_RAM (
        .i_clk   (clk),
        .i_we    (w_l_we),
        .i_waddr (w_l_waddr),
        .i_wdata (w_l_wdata),
        .i_raddr (w_l_raddr),
        .o_rdata (w_l_rdata)
    );

    ram_block #(.Width(W), .Depth(T)) S_RAM (
        .i_clk   (clk),
        .i_we    (w_s_we),
        .i_waddr (r_i),
        .i_wdata (w_s_wdata),
        .i_raddr (w_s_raddr),
        .o_rdata (w_s_rdata)
    );

    // During LOAD_L the key index also selects the L word (i/4).
    assign w_l_raddr = (r_state == StMix) ? r_j : r_i[BAW-1:BAW-CAW];
    assign w_s_raddr = (r_state == StInitS) ? r_i - TAW'(1) : r_i;

    assign w_mix_a  = rotl(w_s_rdata + r_a + r_b, 5'd3);
    assign w_sum_ab = w_mix_a + r_b;
    assign w_mix_b  = rotl(w_l_rdata + w_sum_ab, w_sum_ab[4:0]);

    assign done = (r_state == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_l_we      = 1'b0;
        w_l_waddr   = r_i[BAW-1:BAW-CAW];
        w_l_wdata   = (w_l_rdata << 8) + W'(w_key_rdata);
        w_s_we      = 1'b0;
        w_s_wdata   = w_s_rdata + QW;

        unique case (r_state)
            StIdle: begin
                w_state_nxt = StLoadL;
                w_i_nxt     = TAW'(B - 1);
            end
            StLoadL: begin
                w_l_we = 1'b1;
                if (r_i == '0) begin
                    w_state_nxt = StInitS;
                    w_i_nxt     = TAW'(1);
                end else begin
                    w_i_nxt = r_i - TAW'(1);
                end
            end
            StInitS: begin
                w_s_we = 1'b1;
                if (r_i == TAW'(T - 1)) begin
                    w_state_nxt = StMix;
                    w_i_nxt     = '0;
                end else begin
                    w_i_nxt = r_i + TAW'(1);
                end
            end
            StMix: begin
                w_s_we    = 1'b1;
                w_s_wdata = w_mix_a;
                w_l_we    = 1'b1;
                w_l_waddr = r_j;
                w_l_wdata = w_mix_b;
                w_a_nxt   = w_mix_a;
                w_b_nxt   = w_mix_b;
                w_i_nxt   = (r_i == TAW'(T - 1)) ? '0 : r_i + TAW'(1);
                w_j_nxt   = r_j + CAW'(1);
                w_k_nxt   = r_k + KW'(1);
                if (r_k == KW'(MIX_N - 1)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_hola.sv
// Self-checking bench for hola: compares memory contents and done timing against a
// software RC5-32/12/16 key schedule computed in the bench.
module tb_hola;

    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;
    localparam logic [127:0] KEY0 = 128'hFFFEEEE58684FFF05FFE493853000434;
    localparam int FULL = 125;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_l_load [4];
    logic [31:0] m_s_init [26];
    logic [31:0] m_s [26];
    logic [31:0] m_l [4];
    logic [31:0] m_a1, m_b1;

    hola dut (
        .clk  (clk),
        .rst  (rst),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    task automatic model(input logic [127:0] key);
        logic [31:0] a, b;
        int i, j;
        for (int k = 0; k < 4; k++) m_l[k] = 32'h0;
        for (int k = 15; k >= 0; k--) m_l[k / 4] = (m_l[k / 4] << 8) + {24'h0, key[8 * k +: 8]};
        m_s[0] = P32;
        for (int k = 1; k < 26; k++) m_s[k] = m_s[k - 1] + Q32;
        m_l_load = m_l;
        m_s_init = m_s;
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            a = rl(m_s[i] + a + b, 3);
            m_s[i] = a;
            b = rl(m_l[j] + a + b, int'((a + b) % 32));
            m_l[j] = b;
            if (k == 0) begin
                m_a1 = a;
                m_b1 = b;
            end
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset, preload memories while reset holds the engine idle, then release.
    task automatic start(input logic [127:0] key);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) dut.key_RAM.ram[k] = key[8 * k +: 8];
        for (int k = 0; k < 4; k++) dut.L_RAM.ram[k] = 32'h0;
        dut.S_RAM.ram[0] = P32;
        check("reset_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
    endtask

    task automatic run(input logic [127:0] key, input int stop_at, input bit directed);
        model(key);
        start(key);
        for (int c = 1; c <= stop_at; c++) begin
            @(negedge clk);
            if (c == 1 || c == 60 || c >= 119) check("done_timing", {31'h0, done}, {31'h0, c >= 120});
            if (c == 17) begin
                for (int k = 0; k < 4; k++) check("l_after_load", dut.L_RAM.ram[k], m_l_load[k]);
                if (directed) begin
                    check("l0_const", dut.L_RAM.ram[0], 32'h53000434);
                    check("l3_const", dut.L_RAM.ram[3], 32'hFFFEEEE5);
                end
            end
            if (c == 42) begin
                check("s1_init", dut.S_RAM.ram[1], m_s_init[1]);
                check("s2_init", dut.S_RAM.ram[2], m_s_init[2]);
                check("s25_init", dut.S_RAM.ram[25], P32 + 25 * Q32);
                if (directed) begin
                    check("s1_const", dut.S_RAM.ram[1], 32'h5618CB1C);
                    check("s2_const", dut.S_RAM.ram[2], 32'hF45044D5);
                end
            end
            if (c == 43) begin
                check("mix1_s0", dut.S_RAM.ram[0], m_a1);
                check("mix1_l0", dut.L_RAM.ram[0], m_b1);
                if (directed) begin
                    check("mix1_s0_const", dut.S_RAM.ram[0], 32'hBF0A8B1D);
                    check("mix1_l0_const", dut.L_RAM.ram[0], 32'h224151EA);
                end
            end
        end
        if (stop_at >= 120) begin
            for (int k = 0; k < 26; k++) check("final_s", dut.S_RAM.ram[k], m_s[k]);
            for (int k = 0; k < 4; k++) check("final_l", dut.L_RAM.ram[k], m_l[k]);
        end
    endtask

    initial begin
        logic [127:0] rkey;
        run(KEY0, FULL, 1'b1);
        run(KEY0, 60, 1'b0);
        run(KEY0, FULL, 1'b1);
        run(128'h0, FULL, 1'b0);
        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            run(rkey, FULL, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
